// File: rtl/step_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : step_clk_pkg
//  Purpose  : Shared types and constants for the step clock controller:
//             debounce FSM state encoding and tick-source mode values.
//  Revision : 1.0 - initial release
// ============================================================================
package step_clk_pkg;

    // Debounce FSM states, fixed 2-bit encoding
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    // Tick source selection
    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Two-flop synchronizer plus four-state debounce FSM for the raw
//             step button. Produces a registered debounced level and a
//             one-cycle press event per qualified press.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_COUNT = 1000000,
    parameter int DEB_WIDTH = 20
) (
    input  logic clk_in,
    input  logic rst,
    input  logic step_btn,
    output logic btn_level,
    output logic press_evt
);
    import step_clk_pkg::*;

    // Counter value at which the final stable sample qualifies a level change
    localparam logic [DEB_WIDTH-1:0] c_deb_last = DEB_WIDTH'(DEB_COUNT - 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    deb_state_t           state_q, state_d;
    logic [DEB_WIDTH-1:0] cnt_q, cnt_d;
    logic                 btn_level_q, btn_level_d;
    logic                 btn_s;

    assign btn_s = sync2_q;

    // State register: synchronizer, FSM state, debounce counter, level
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_level_q <= btn_level_d;
        end
    end

    // Next-state logic: a level change is accepted only after an unbroken run
    // of opposite samples; any contrary sample drops back to the stable state
    always_comb begin
        sync1_d     = step_btn;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        btn_level_d = btn_level_q;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    cnt_d   = '0;
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == c_deb_last) begin
                    cnt_d       = '0;
                    state_d     = PRESSED;
                    btn_level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DEB_WIDTH'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    cnt_d   = '0;
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    cnt_d   = '0;
                    state_d = PRESSED;
                end else if (cnt_q == c_deb_last) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    btn_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + DEB_WIDTH'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: press event fires on the cycle the press is qualified
    always_comb begin
        press_evt = (state_q == PRESS_WAIT) && btn_s && (cnt_q == c_deb_last);
        btn_level = btn_level_q;
    end

endmodule
`default_nettype wire

// File: rtl/step_clock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : step_clock_ctrl
//  Purpose  : Generates a single-cycle clock-enable tick for the pipeline core,
//             either periodically from a divide counter (auto) or once per
//             debounced step-button press (manual). Counts issued ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module step_clock_ctrl #(
    parameter int DIV_WIDTH = 16,
    parameter int DEB_COUNT = 1000000,
    parameter int DEB_WIDTH = 20,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 run_en,
    input  logic                 step_btn,
    output logic                 tick,
    output logic                 btn_level,
    output logic [CNT_WIDTH-1:0] tick_cnt
);
    import step_clk_pkg::*;

    logic                 mode_q, mode_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 tick_q, tick_d;
    logic [CNT_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic                 press_evt;
    logic                 mode_switch;
    logic                 auto_term;

    btn_debounce #(
        .DEB_COUNT (DEB_COUNT),
        .DEB_WIDTH (DEB_WIDTH)
    ) u_btn_debounce (
        .clk_in    (clk_in),
        .rst       (rst),
        .step_btn  (step_btn),
        .btn_level (btn_level),
        .press_evt (press_evt)
    );

    // Registers: mode history, divide counter, tick pulse and tick count
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_AUTO;
            div_q      <= '0;
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Next values: a mode change restarts the divider and suppresses the tick
    // for that cycle so a source change never emits a stray pulse
    always_comb begin
        mode_d      = mode;
        mode_switch = (mode != mode_q);
        auto_term   = run_en && (&div_q);

        if (mode_switch || (mode_q == MODE_MANUAL)) begin
            div_d = '0;
        end else if (run_en) begin
            div_d = div_q + DIV_WIDTH'(1);
        end else begin
            div_d = div_q;
        end

        if (mode_switch) begin
            tick_d = 1'b0;
        end else if (mode_q == MODE_AUTO) begin
            tick_d = auto_term;
        end else begin
            tick_d = press_evt;
        end

        tick_cnt_d = tick_cnt_q + CNT_WIDTH'(tick_q);
    end

    assign tick     = tick_q;
    assign tick_cnt = tick_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_step_clock_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_step_clock_ctrl
//  Purpose  : Self-checking bench for step_clock_ctrl with a behavioural
//             reference model (run-length debounce, modulo period counter).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_step_clock_ctrl;

    localparam int DIV_WIDTH = 4;
    localparam int DEB_COUNT = 4;
    localparam int DEB_WIDTH = 4;
    localparam int CNT_WIDTH = 8;
    localparam int PERIOD    = 1 << DIV_WIDTH;
    localparam int CNT_MOD   = 1 << CNT_WIDTH;

    logic                 clk_in = 1'b0;
    logic                 rst = 1'b1;
    logic                 mode = 1'b0;
    logic                 run_en = 1'b0;
    logic                 step_btn = 1'b0;
    logic                 tick;
    logic                 btn_level;
    logic [CNT_WIDTH-1:0] tick_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    logic m_sync1, m_sync2, m_level, m_tick, m_mode_q;
    int   m_run, m_div, m_cnt;

    step_clock_ctrl #(
        .DIV_WIDTH (DIV_WIDTH),
        .DEB_COUNT (DEB_COUNT),
        .DEB_WIDTH (DEB_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .mode      (mode),
        .run_en    (run_en),
        .step_btn  (step_btn),
        .tick      (tick),
        .btn_level (btn_level),
        .tick_cnt  (tick_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_clear();
        m_sync1 = 0; m_sync2 = 0; m_level = 0; m_tick = 0; m_mode_q = 0;
        m_run = 0; m_div = 0; m_cnt = 0; cyc = 0;
    endtask

    // One clock: advance the model with the pre-edge inputs, then wait for the
    // edge and return at the following falling edge for checking/driving.
    task automatic step();
        logic s, evt, sw, t;
        s   = m_sync2;
        evt = 1'b0;
        sw  = (mode !== m_mode_q);
        // Debounce: accept a level change after DEB_COUNT+1 consecutive
        // synchronized samples that disagree with the current level
        if (s != m_level) begin
            m_run++;
            if (m_run == DEB_COUNT + 1) begin
                m_level = s;
                m_run   = 0;
                evt     = s;
            end
        end else begin
            m_run = 0;
        end
        if (sw)             t = 1'b0;
        else if (!m_mode_q) t = run_en && (m_div == PERIOD - 1);
        else                t = evt;
        m_cnt = (m_cnt + (m_tick ? 1 : 0)) % CNT_MOD;
        if (sw || mode)  m_div = 0;
        else if (run_en) m_div = (m_div + 1) % PERIOD;
        m_tick   = t;
        m_mode_q = mode;
        m_sync2  = m_sync1;
        m_sync1  = step_btn;
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        rst = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        mode = 0; run_en = 0; step_btn = 0;
        apply_reset();
        n_cmp++;
        if ({tick, btn_level, tick_cnt} !== {1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_state: got tick=%b lvl=%b cnt=%0d want 0/0/0", tick, btn_level, tick_cnt);
        end
    endtask

    task automatic test_auto_run();
        int first_tick;
        first_tick = -1;
        mode = 0; run_en = 1; step_btn = 0;
        apply_reset();
        for (int i = 0; i < 65; i++) begin
            step();
            if (tick === 1'b1 && first_tick < 0) first_tick = cyc;
            n_cmp++;
            if ({tick, btn_level, tick_cnt} !== {m_tick, m_level, m_cnt[7:0]}) begin
                n_err++;
                $display("FAIL auto_run cyc=%0d: got %b/%b/%0d want %b/%b/%0d", cyc, tick, btn_level, tick_cnt, m_tick, m_level, m_cnt);
            end
        end
        n_cmp++;
        if (first_tick != PERIOD) begin
            n_err++;
            $display("FAIL auto_first_tick: got edge %0d want %0d", first_tick, PERIOD);
        end
        n_cmp++;
        if (tick_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL auto_cnt_65: got %0d want 4", tick_cnt);
        end
    endtask

    task automatic test_auto_pause();
        logic [7:0] held;
        int next_tick;
        next_tick = -1;
        for (int i = 0; i < 5; i++) step();
        run_en = 0;
        held = tick_cnt;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (tick !== 1'b0 || tick_cnt !== held || tick_cnt !== m_cnt[7:0]) begin
                n_err++;
                $display("FAIL auto_pause cyc=%0d: got tick=%b cnt=%0d want 0/%0d", cyc, tick, tick_cnt, held);
            end
        end
        run_en = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick === 1'b1 && next_tick < 0) next_tick = cyc;
        end
        n_cmp++;
        if (next_tick != 4 * PERIOD + PERIOD + 10) begin
            n_err++;
            $display("FAIL auto_pause_stretch: got edge %0d want %0d", next_tick, 5 * PERIOD + 10);
        end
    endtask

    task automatic test_manual_press();
        int ticks, first_tick, base;
        logic [7:0] cnt0;
        ticks = 0; first_tick = -1;
        mode = 1; run_en = 0; step_btn = 0;
        for (int i = 0; i < 4; i++) step();
        cnt0 = tick_cnt;
        base = cyc;
        step_btn = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = cyc - base;
            end
            n_cmp++;
            if ({tick, btn_level, tick_cnt} !== {m_tick, m_level, m_cnt[7:0]}) begin
                n_err++;
                $display("FAIL manual_press cyc=%0d: got %b/%b/%0d want %b/%b/%0d", cyc, tick, btn_level, tick_cnt, m_tick, m_level, m_cnt);
            end
        end
        n_cmp++;
        if (ticks != 1 || first_tick != DEB_COUNT + 3 || btn_level !== 1'b1) begin
            n_err++;
            $display("FAIL manual_latency: got ticks=%0d edge=%0d lvl=%b want 1/%0d/1", ticks, first_tick, btn_level, DEB_COUNT + 3);
        end
        step_btn = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (tick !== 1'b0) begin
                n_err++;
                $display("FAIL manual_release_tick cyc=%0d: got tick=%b want 0", cyc, tick);
            end
        end
        n_cmp++;
        if (btn_level !== 1'b0 || tick_cnt !== cnt0 + 8'd1) begin
            n_err++;
            $display("FAIL manual_release: got lvl=%b cnt=%0d want 0/%0d", btn_level, tick_cnt, cnt0 + 8'd1);
        end
    endtask

    task automatic test_bounce();
        logic pat [7];
        int ticks, first_tick, base;
        logic [7:0] cnt0;
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ticks = 0; first_tick = -1;
        cnt0 = tick_cnt;
        base = cyc;
        for (int i = 0; i < 22; i++) begin
            step_btn = (i < 7) ? pat[i] : 1'b1;
            step();
            if (tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = cyc - base;
            end
            n_cmp++;
            if ({tick, btn_level, tick_cnt} !== {m_tick, m_level, m_cnt[7:0]}) begin
                n_err++;
                $display("FAIL bounce cyc=%0d: got %b/%b/%0d want %b/%b/%0d", cyc, tick, btn_level, tick_cnt, m_tick, m_level, m_cnt);
            end
        end
        n_cmp++;
        if (ticks != 1 || first_tick != 14 || tick_cnt !== cnt0 + 8'd1) begin
            n_err++;
            $display("FAIL bounce_summary: got ticks=%0d edge=%0d cnt=%0d want 1/14/%0d", ticks, first_tick, tick_cnt, cnt0 + 8'd1);
        end
        step_btn = 0;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_reset_mid_press();
        int ticks, first_tick;
        ticks = 0; first_tick = -1;
        mode = 1; step_btn = 1;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tick, btn_level, tick_cnt} !== {1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_mid_press: got tick=%b lvl=%b cnt=%0d want 0/0/0", tick, btn_level, tick_cnt);
        end
        @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 12; i++) begin
            step();
            if (tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = cyc;
            end
        end
        n_cmp++;
        if (ticks != 1 || first_tick != DEB_COUNT + 3 || tick_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL reset_repress: got ticks=%0d edge=%0d cnt=%0d want 1/%0d/1", ticks, first_tick, tick_cnt, DEB_COUNT + 3);
        end
        step_btn = 0;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_mode_switch();
        int ticks;
        ticks = 0;
        mode = 0; run_en = 1; step_btn = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) step();
        mode = 1;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (ticks != 0 || tick_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL mode_switch_no_tick: got ticks=%0d cnt=%0d want 0/0", ticks, tick_cnt);
        end
        mode = 0; run_en = 0; step_btn = 1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (ticks != 0 || tick_cnt !== 8'd0 || btn_level !== 1'b1) begin
            n_err++;
            $display("FAIL auto_press_ignored: got ticks=%0d cnt=%0d lvl=%b want 0/0/1", ticks, tick_cnt, btn_level);
        end
        step_btn = 0;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_random();
        int seg;
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 5) == 0) mode = ~mode;
            run_en   = ($urandom_range(0, 3) != 0);
            step_btn = $urandom_range(0, 1);
            seg      = $urandom_range(1, 12);
            for (int i = 0; i < seg; i++) begin
                if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
                step();
                n_cmp++;
                if ({tick, btn_level, tick_cnt} !== {m_tick, m_level, m_cnt[7:0]}) begin
                    n_err++;
                    $display("FAIL random cyc=%0d: got %b/%b/%0d want %b/%b/%0d", cyc, tick, btn_level, tick_cnt, m_tick, m_level, m_cnt);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_auto_run();
        test_auto_pause();
        test_manual_press();
        test_bounce();
        test_reset_mid_press();
        test_mode_switch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_clock_ctrl.md
Name: step_clock_ctrl

Overview:
- Consumer-side companion to the team's free-running clock divider.
- Runs entirely in the fast clk_in domain and produces a single-cycle clock-enable pulse, `tick`, for the pipeline core. The core advances only on `tick`; no derived clocks.
- Two tick sources, selected by `mode`:
  - auto: periodic tick from an internal divide counter;
  - manual: one tick per debounced press of an asynchronous step button.

Parameters:
- DIV_WIDTH, 16: divide counter width; auto tick period = 2^DIV_WIDTH clk_in cycles.
- DEB_COUNT, 1000000: consecutive stable synchronized samples required to accept a button level change (≥2).
- DEB_WIDTH, 20: debounce counter width; must satisfy 2^DEB_WIDTH > DEB_COUNT.
- CNT_WIDTH, 16: width of the tick counter output.

Ports:
- clk_in    in   1          fast system clock.
- rst       in   1          asynchronous, active-high reset.
- mode      in   1          0 = auto, 1 = manual step; synchronous to clk_in.
- run_en    in   1          auto-mode enable; ignored in manual mode.
- step_btn  in   1          raw asynchronous push button, active-high.
- tick      out  1          one-cycle clock-enable pulse, registered.
- btn_level out  1          debounced button level, registered.
- tick_cnt  out  CNT_WIDTH  count of ticks issued, wraps.

Behaviour:

Reset and clocking:
- Reset: rst asynchronous, active-high; clock clk_in.
- On rst, all registers clear: tick=0, btn_level=0, tick_cnt=0, div counter=0, debounce counter=0, sync flops=0, FSM=IDLE, mode_q=0.
- Reset mid-press or mid-debounce discards progress. If the button is still held after rst deasserts, it is qualified as a new press after full debounce.

Synchronizer:
- step_btn passes through a 2-flop synchronizer giving btn_s.
- Only btn_s is used downstream.

Debounce FSM (states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT):
- IDLE: on btn_s=1, clear the counter and go to PRESS_WAIT.
- PRESS_WAIT: on btn_s=1, increment the counter.
  - When the counter reaches DEB_COUNT-1 with btn_s=1, go to PRESSED, set btn_level=1, and raise press_evt for one cycle.
  - On btn_s=0, return to IDLE and clear the counter.
- PRESSED: on btn_s=0, clear the counter and go to RELEASE_WAIT.
- RELEASE_WAIT: mirror of PRESS_WAIT.
  - Stable 0 for DEB_COUNT cycles: go to IDLE and set btn_level=0.
  - Any btn_s=1 sample: return to PRESSED with no new press_evt.
- A held button produces exactly one press_evt.
- The FSM runs in both modes. press_evt in auto mode is discarded.

Auto divider:
- mode_q registers mode.
- When mode != mode_q, the div counter clears to 0 that cycle. No tick is issued on the switch cycle.
- In auto mode with run_en=1, the counter increments every cycle and wraps at 2^DIV_WIDTH.
- Auto tick is raised when the counter equals all-ones and run_en=1, i.e. once per 2^DIV_WIDTH cycles.
- run_en=0 holds the counter at its current value; no ticks.
- In manual mode the counter is held at 0.

Tick:
- tick (registered) = (mode_q==0 & auto terminal) | (mode_q==1 & press_evt).
- Never high on two consecutive cycles unless DIV_WIDTH=0, which is illegal.

Latency:
- Manual: tick is high in the clock cycle starting at the (2+DEB_COUNT+1)th rising clk_in edge after step_btn is first sampled high, provided it stays high.
- Auto: first tick after reset or mode entry occurs at 2^DIV_WIDTH+1 cycles.

Tick counter:
- tick_cnt increments by 1 on every cycle where tick=1.
- Wraps from all-ones to 0. Unaffected by mode changes.

Decomposition:
- Shared package step_clk_pkg:
  - FSM state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, 2-bit encoding 0..3);
  - MODE_AUTO=1'b0 and MODE_MANUAL=1'b1 constants.
- Sub-module btn_debounce: synchronizer plus FSM, outputs btn_level and press_evt, parameters DEB_COUNT/DEB_WIDTH.
- Top module: divider counter, mode handling, tick and tick_cnt.

Test Plan (DIV_WIDTH=4, DEB_COUNT=4, CNT_WIDTH=8):
- Auto run: mode=0, run_en=1 from reset → tick pulses every 16 cycles, first at cycle 17; tick_cnt=4 after 65 cycles.
- Auto pause: deassert run_en for 10 cycles mid-period → tick period stretches by exactly 10 cycles, no spurious tick; tick_cnt unchanged during the pause.
- Manual clean press: mode=1, step_btn high for 20 cycles → exactly one tick, 7 edges after the rise; btn_level=1; release for 10 cycles → btn_level=0, no tick.
- Bounce rejection: step_btn toggles 1,1,0,1,1,1,0 per cycle, then high → no tick until 4 stable synchronized highs; then exactly one tick; tick_cnt +1.
- Mode switch: in auto at counter=10 switch to manual → counter clears, no auto tick; press ignored in auto → tick_cnt unchanged.
- Reset mid-press: assert rst during PRESS_WAIT with button held → all outputs 0 immediately; after release of rst, one tick follows after 2+4+1 cycles.
